// File: rtl/fft_bf_r2_pipe_if.sv
// fft_bf_r2_pipe_if
//   Bundles the input-pair and output-pair streams of the radix-2 butterfly.
//   slave  : butterfly side (consumes a/b/tw, produces y0/y1)
//   master : driver side (feeds a/b/tw, consumes y0/y1)
//   Signals:
//     in_valid/in_ready    input pair handshake
//     inv                  1 = IFFT (conjugate twiddle), travels with the pair
//     a_*, b_*             complex operands, signed DW
//     tw_*                 complex twiddle, signed Q1.(TW-1)
//     out_valid/out_ready  output pair handshake
//     y0_*, y1_*           a + b*W and a - b*W, signed DW
interface fft_bf_r2_pipe_if #(
  parameter int DW = 16,
  parameter int TW = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 inv;
  logic signed [DW-1:0] a_re, a_im;
  logic signed [DW-1:0] b_re, b_im;
  logic signed [TW-1:0] tw_re, tw_im;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] y0_re, y0_im;
  logic signed [DW-1:0] y1_re, y1_im;

  modport slave (
    input  in_valid, inv, a_re, a_im, b_re, b_im, tw_re, tw_im, out_ready,
    output in_ready, out_valid, y0_re, y0_im, y1_re, y1_im
  );

  modport master (
    output in_valid, inv, a_re, a_im, b_re, b_im, tw_re, tw_im, out_ready,
    input  in_ready, out_valid, y0_re, y0_im, y1_re, y1_im
  );
endinterface

// File: rtl/fft_bf_r2_pipe.sv
// fft_bf_r2_pipe
//   Pipelined radix-2 DIT butterfly: y0 = a + b*W, y1 = a - b*W.
//   Three stages: S1 multiply, S2 combine + round, S3 add/sub, scale, limit.
//   One global advance: every stage moves when the output slot is free or
//   being taken, so the whole pipe stalls as a unit under backpressure.
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     bf       fft_bf_r2_pipe_if.slave (input pair stream, output pair stream)
//     clr_ovf  synchronous clear of the sticky overflow flag
//     ovf      sticky saturation flag
//   Parameters: DW data width, TW twiddle width, SCALE 1 = halve outputs.
//   Build option BF_SAT_EN: defined -> S3 saturates and drives ovf;
//   undefined -> S3 wraps to DW bits, ovf is 0 and clr_ovf is ignored.
module fft_bf_r2_pipe #(
  parameter int DW    = 16,
  parameter int TW    = 16,
  parameter int SCALE = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  fft_bf_r2_pipe_if.slave bf,
  input  logic            clr_ovf,
  output logic            ovf
);
  localparam int STAGES = 3;
  localparam int PW     = DW + TW + 1;  // product width
  localparam int SW     = PW + 1;       // product sum/difference width
  localparam int TDW    = DW + 2;       // rounded b*W width
  localparam int RW     = DW + 3;       // add/sub width
  localparam logic signed [SW-1:0] RND = SW'(1) << (TW - 2);

  // ---------------- handshake / valid pipe ----------------
  logic              adv;
  logic [STAGES:1]   vld_q;
  logic [STAGES:0]   vld_pipe;  // [0] = accepted this cycle, [k] = Sk valid

  assign adv          = ~vld_q[STAGES] | bf.out_ready;
  assign vld_pipe     = {vld_q, bf.in_valid & adv};
  assign bf.in_ready  = adv;
  assign bf.out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)  vld_q <= '0;
    else if (adv)  vld_q <= vld_pipe[STAGES-1:0];

  // ---------------- S1: multiply ----------------
  // wi is one bit wider so negating the most negative twiddle is exact.
  logic signed [TW:0]     wi;
  logic signed [PW-1:0]   p_rr_d, p_iw_d, p_rw_d, p_ir_d;
  logic signed [PW-1:0]   p_rr_q, p_iw_q, p_rw_q, p_ir_q;
  logic signed [DW-1:0]   a_re1_q, a_im1_q;

  always_comb begin
    wi     = bf.inv ? -((TW+1)'(bf.tw_im)) : (TW+1)'(bf.tw_im);
    p_rr_d = PW'(bf.b_re) * PW'(bf.tw_re);
    p_iw_d = PW'(bf.b_im) * PW'(wi);
    p_rw_d = PW'(bf.b_re) * PW'(wi);
    p_ir_d = PW'(bf.b_im) * PW'(bf.tw_re);
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      p_rr_q  <= '0;
      p_iw_q  <= '0;
      p_rw_q  <= '0;
      p_ir_q  <= '0;
      a_re1_q <= '0;
      a_im1_q <= '0;
    end else if (vld_pipe[0]) begin
      p_rr_q  <= p_rr_d;
      p_iw_q  <= p_iw_d;
      p_rw_q  <= p_rw_d;
      p_ir_q  <= p_ir_d;
      a_re1_q <= bf.a_re;
      a_im1_q <= bf.a_im;
    end

  // ---------------- S2: combine and round ----------------
  // Round half up back to data scale; the DW+2 result cannot overflow
  // because |b*W| < 2^(DW+TW-1).
  logic signed [SW-1:0]  p_re, p_im;
  logic signed [TDW-1:0] t_re_d, t_im_d, t_re_q, t_im_q;
  logic signed [DW-1:0]  a_re2_q, a_im2_q;

  always_comb begin
    p_re   = SW'(p_rr_q) - SW'(p_iw_q);
    p_im   = SW'(p_rw_q) + SW'(p_ir_q);
    t_re_d = TDW'((p_re + RND) >>> (TW - 1));
    t_im_d = TDW'((p_im + RND) >>> (TW - 1));
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      t_re_q  <= '0;
      t_im_q  <= '0;
      a_re2_q <= '0;
      a_im2_q <= '0;
    end else if (adv && vld_q[1]) begin
      t_re_q  <= t_re_d;
      t_im_q  <= t_im_d;
      a_re2_q <= a_re1_q;
      a_im2_q <= a_im1_q;
    end

  // ---------------- S3: add/sub, scale, limit ----------------
  // s[0..3] = y0_re, y0_im, y1_re, y1_im before limiting
  logic signed [RW-1:0] s [4];
  logic signed [DW-1:0] y_q [4];
  logic                 s3_ld;

  assign s3_ld = adv & vld_q[2];

  always_comb begin
    s[0] = RW'(a_re2_q) + RW'(t_re_q);
    s[1] = RW'(a_im2_q) + RW'(t_im_q);
    s[2] = RW'(a_re2_q) - RW'(t_re_q);
    s[3] = RW'(a_im2_q) - RW'(t_im_q);
    if (SCALE != 0)
      for (int k = 0; k < 4; k++) s[k] = (s[k] + RW'(1)) >>> 1;
  end

`ifdef BF_SAT_EN
  localparam logic signed [RW-1:0] SMAX = {{4{1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] SMIN = {{4{1'b1}}, {(DW-1){1'b0}}};

  function automatic logic oor(input logic signed [RW-1:0] v);
    return (v > SMAX) || (v < SMIN);
  endfunction

  function automatic logic signed [DW-1:0] lim(input logic signed [RW-1:0] v);
    if (v > SMAX)      return {1'b0, {(DW-1){1'b1}}};
    else if (v < SMIN) return {1'b1, {(DW-1){1'b0}}};
    else               return DW'(v);
  endfunction

  logic ovf_hit, ovf_d, ovf_q;

  always_comb begin
    ovf_hit = 1'b0;
    for (int k = 0; k < 4; k++) ovf_hit = ovf_hit | oor(s[k]);
    // a fresh overflow beats a simultaneous clear
    ovf_d = ovf_q;
    if (clr_ovf)           ovf_d = 1'b0;
    if (s3_ld && ovf_hit)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;

  assign ovf = ovf_q;
`else
  function automatic logic signed [DW-1:0] lim(input logic signed [RW-1:0] v);
    return DW'(v);  // two's-complement wrap
  endfunction

  logic unused_clr_ovf;
  assign unused_clr_ovf = clr_ovf;
  assign ovf            = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) y_q[k] <= '0;
    end else if (s3_ld) begin
      for (int k = 0; k < 4; k++) y_q[k] <= lim(s[k]);
    end

  assign bf.y0_re = y_q[0];
  assign bf.y0_im = y_q[1];
  assign bf.y1_re = y_q[2];
  assign bf.y1_im = y_q[3];
endmodule

// File: doc/fft_bf_r2_pipe.md
Name: fft_bf_r2_pipe

Overview:
Parametrised, pipelined radix-2 DIT butterfly for the FFT/IFFT datapath. Each cycle it accepts one complex pair (a, b) plus a twiddle W and produces y0 = a + b*W and y1 = a - b*W.
- Per-sample IFFT mode conjugates W.
- Per-block optional divide-by-2 scaling.
- Valid/ready handshake with full backpressure, so it can be chained stage-to-stage or fed from a sample buffer.

Parameters:
DW, 16, data width of each re/im component (signed, two's complement)
TW, 16, twiddle width; twiddle is signed Q1.(TW-1), so 2^(TW-1)-1 represents +1.0
SCALE, 0, 1 = outputs are divided by 2 with rounding (per-stage scaling); 0 = no scaling

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  input pair valid
in_ready  out  1  block can accept input this cycle
inv  in  1  1 = IFFT (use conj(W)); travels with the sample
a_re, a_im  in  DW each  operand a
b_re, b_im  in  DW each  operand b
tw_re, tw_im  in  TW each  twiddle W
out_valid  out  1  output pair valid
out_ready  in  1  downstream accepts output
y0_re, y0_im  out  DW each  a + b*W (optionally scaled)
y1_re, y1_im  out  DW each  a - b*W (optionally scaled)
clr_ovf  in  1  synchronous clear of ovf
ovf  out  1  sticky saturation flag

Behaviour:
- Reset (reset_n low, asynchronous):
  - All pipeline registers, valid bits, y* outputs, out_valid and ovf go to 0.
  - Reset takes effect immediately, including mid-stream; in-flight samples are discarded.
- Pipeline: 3 stages (S1, S2, S3), global advance signal adv = ~out_valid | out_ready.
  - in_ready = adv (combinational).
  - A transfer happens when in_valid & in_ready.
  - When adv = 1, every stage loads from its predecessor. S1 valid is loaded with in_valid & in_ready.
  - When adv = 0, all stages hold, and outputs stay stable while out_valid = 1 & out_ready = 0.
  - Latency: 3 cycles from accepted input to out_valid with no stall. Throughput: 1 pair per cycle.
- S1 (multiply):
  - Effective imaginary twiddle wi = inv ? -tw_im : tw_im, computed in TW+1 bits so that negating -2^(TW-1) is exact.
  - Register the four products b_re*tw_re, b_im*wi, b_re*wi, b_im*tw_re (full width, DW+TW+1).
  - Register a and inv alongside the products.
- S2 (combine and round):
  - p_re = b_re*tw_re - b_im*wi
  - p_im = b_re*wi + b_im*tw_re
  - t = (p + 2^(TW-2)) >>> (TW-1), arithmetic shift, round half up.
  - t is held in DW+2 bits. No saturation at this point.
- S3 (add/sub, scale, limit):
  - s0 = a + t, s1 = a - t, computed in DW+3 bits.
  - If SCALE = 1: s = (s + 1) >>> 1.
  - Limit the result to DW bits (see Optional Feature) and register it to y*.
- ovf:
  - Set on any S3 load where any of the four components exceeds the DW range.
  - clr_ovf = 1 clears it on the next edge.
  - If clear and set occur on the same edge, set wins.
- Boundary cases:
  - tw = (-2^(TW-1), 0) gives exactly -b.
  - in_valid while in_ready = 0: the input is ignored, not queued.
  - Inputs are not sampled when in_valid = 0.

Optional Feature:
BF_SAT_EN
- Defined: S3 saturates each component to [-2^(DW-1), 2^(DW-1)-1] and drives ovf as specified above.
- Undefined: S3 keeps the low DW bits (two's-complement wrap); ovf is tied to 0 and clr_ovf is unused.

Test Plan:
1. Identity twiddle, DW = TW = 16, SCALE = 0: a = (1000, 0), b = (1000, 0), tw = (32767, 0), inv = 0 -> 3 cycles later y0 = (2000, 0), y1 = (0, 0), out_valid = 1 for exactly 1 cycle.
2. W8^1 twiddle: a = (0, 0), b = (10000, 0), tw = (23170, -23170).
   - inv = 0 -> y0 = (7071, -7071), y1 = (-7071, 7071).
   - Same pair with inv = 1 -> y0 = (7071, 7071), y1 = (-7071, -7071).
3. Saturation (BF_SAT_EN defined): a = b = (30000, 0), tw = (32767, 0).
   - SCALE = 0 -> y0_re = 32767, y1_re = 1, ovf = 1.
   - Then pulse clr_ovf -> ovf = 0 next cycle.
   - SCALE = 1 -> y0_re = 30000, y1_re = 1, ovf stays 0.
4. Backpressure: stream 5 distinct pairs back-to-back, hold out_ready = 0 for 4 cycles after the first out_valid.
   - in_ready is low during the hold.
   - y* is stable during the hold.
   - All 5 results emerge in order with no loss or duplication.
5. Reset mid-stream: drive reset_n low with 2 pairs in flight.
   - out_valid, y* and ovf read 0 immediately.
   - After release, the next accepted pair appears 3 cycles later; no stale data appears.
6. Edge twiddle: b = (1234, -567), tw = (-32768, 0) -> t = (-1234, 567) exactly; with a = (0, 0), y0 = (-1234, 567), y1 = (1234, -567).
